// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 matrix keypad scanner.
//   scanState_t   : scanner FSM states (scan, debounce a press, wait for release)
//   KEY_CLEAR     : key code that clears the digit register ('*' on the keypad)
//   COL_RESET     : column drive pattern after reset (column 0 driven low)
//   ROW_IDLE      : synchronizer reset value, i.e. "no row pulled low"
//   lowestLowRow  : priority pick of the lowest-index row that reads low
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } scanState_t;

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROW_IDLE  = 4'b1111;

  // Rows are active low. When several keys in one column are down, the
  // lowest row index wins so that the result is deterministic.
  function automatic logic [1:0] lowestLowRow(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    casez (rows)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_key_map.sv
// -----------------------------------------------------------------------------
// key_map
// Combinational translation of a keypad position into its hex key code.
// Layout (rows 0..3 top to bottom, columns 0..3 left to right):
//   1 2 3 A
//   4 5 6 B
//   7 8 9 C
//   E 0 F D      (E is '*', F is '#')
// Ports:
//   i_row  in  2  row index of the pressed key
//   i_col  in  2  column index of the pressed key
//   o_key  out 4  hex key code
// -----------------------------------------------------------------------------
module key_map (
  input  logic [1:0] i_row,
  input  logic [1:0] i_col,
  output logic [3:0] o_key
);

  // Plain lookup on the concatenated {row, column} position.
  always_comb begin
    o_key = 4'h0;
    case ({i_row, i_col})
      4'b00_00: o_key = 4'h1;
      4'b00_01: o_key = 4'h2;
      4'b00_10: o_key = 4'h3;
      4'b00_11: o_key = 4'hA;
      4'b01_00: o_key = 4'h4;
      4'b01_01: o_key = 4'h5;
      4'b01_10: o_key = 4'h6;
      4'b01_11: o_key = 4'hB;
      4'b10_00: o_key = 4'h7;
      4'b10_01: o_key = 4'h8;
      4'b10_10: o_key = 4'h9;
      4'b10_11: o_key = 4'hC;
      4'b11_00: o_key = 4'hE;
      4'b11_01: o_key = 4'h0;
      4'b11_10: o_key = 4'hF;
      4'b11_11: o_key = 4'hD;
      default:  o_key = 4'h0;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces each
// press and release, and collects typed decimal digits into a four-digit BCD
// register that feeds the seven-segment display directly.
// Parameters:
//   SCAN_DIV  clock cycles each column is driven (>= 4 so the row
//             synchronizer settles inside one dwell)
//   DEBOUNCE  identical samples needed to accept a press or a release (>= 1)
// Ports:
//   clk       in  1   clock, rising edge
//   rst_n     in  1   synchronous active-low reset
//   row       in  4   keypad rows, active low, asynchronous to clk
//   col       out 4   column drive, active low, one bit low at a time
//   keyValid  out 1   one-cycle pulse per accepted press
//   keyCode   out 4   hex code of the last accepted key
//   digits    out 16  four BCD digits, [15:12] most significant
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        keyValid,
  output logic [3:0]  keyCode,
  output logic [15:0] digits
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);
  localparam logic             INSTANT_ACCEPT = (DEBOUNCE <= 1);

  logic [3:0]       r_rowMeta;
  logic [3:0]       r_rowSync;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_col;
  logic [1:0]       r_colIdx;
  scanState_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_keyRow;
  logic [1:0]       r_keyCol;
  logic             r_keyValid;
  logic [3:0]       r_keyCode;
  logic [15:0]      r_digits;

  logic             w_sampleEdge;
  logic             w_anyLow;
  logic [1:0]       w_rowIdx;
  logic [CNT_W-1:0] w_cntInc;
  logic [1:0]       w_mapRow;
  logic [1:0]       w_mapCol;
  logic [3:0]       w_mappedKey;
  logic [15:0]      w_digitsNext;

  // The rows come straight from the keypad and are asynchronous to clk, so
  // they pass through two flops before any decision looks at them. Reset
  // loads "all rows high" so nothing looks pressed while the chain refills.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rowMeta <= ROW_IDLE;
      r_rowSync <= ROW_IDLE;
    end else begin
      r_rowMeta <= row;
      r_rowSync <= r_rowMeta;
    end
  end

  // Dwell divider. Its last count marks the end of the current column's
  // dwell, which is the only moment the FSM looks at the rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_sampleEdge = (r_div == DIV_LAST);
  assign w_anyLow     = ~&r_rowSync;
  assign w_rowIdx     = lowestLowRow(r_rowSync);
  assign w_cntInc     = r_cnt + 1'b1;

  // With single-sample debounce the press is accepted while still in SCAN,
  // before the position has been latched, so the live row and column feed
  // the decoder there. Everywhere else the latched position is used.
  assign w_mapRow = (r_state == ST_SCAN) ? w_rowIdx : r_keyRow;
  assign w_mapCol = (r_state == ST_SCAN) ? r_colIdx : r_keyCol;

  key_map u_keyMap (
    .i_row (w_mapRow),
    .i_col (w_mapCol),
    .o_key (w_mappedKey)
  );

  // Digit register update for an accepted key: decimal keys shift in from
  // the right and push the oldest digit out, '*' clears, and the letter keys
  // and '#' leave the display alone.
  always_comb begin
    w_digitsNext = r_digits;
    if (w_mappedKey <= 4'd9) begin
      w_digitsNext = {r_digits[11:0], w_mappedKey};
    end else if (w_mappedKey == KEY_CLEAR) begin
      w_digitsNext = 16'h0000;
    end
  end

  // Scanner FSM together with the column drive and the registered outputs.
  // The column only moves on from SCAN (or when falling back to SCAN), so
  // during DEBOUNCE and HELD the same key stays under observation. One
  // counter serves both phases: press confirmations in DEBOUNCE, consecutive
  // released samples in HELD. A key that is held down therefore produces one
  // accept and nothing more until it has been seen released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_SCAN;
      r_col      <= COL_RESET;
      r_colIdx   <= 2'd0;
      r_cnt      <= '0;
      r_keyRow   <= 2'd0;
      r_keyCol   <= 2'd0;
      r_keyValid <= 1'b0;
      r_keyCode  <= 4'h0;
      r_digits   <= 16'h0000;
    end else begin
      r_keyValid <= 1'b0;
      if (w_sampleEdge) begin
        unique case (r_state)
          ST_SCAN: begin
            if (w_anyLow) begin
              r_keyRow <= w_rowIdx;
              r_keyCol <= r_colIdx;
              if (INSTANT_ACCEPT) begin
                r_state    <= ST_HELD;
                r_cnt      <= '0;
                r_keyValid <= 1'b1;
                r_keyCode  <= w_mappedKey;
                r_digits   <= w_digitsNext;
              end else begin
                r_state <= ST_DEBOUNCE;
                r_cnt   <= CNT_W'(1);
              end
            end else begin
              r_col    <= {r_col[2:0], r_col[3]};
              r_colIdx <= r_colIdx + 1'b1;
            end
          end
          ST_DEBOUNCE: begin
            if (w_anyLow && (w_rowIdx == r_keyRow)) begin
              if (w_cntInc == CNT_DONE) begin
                r_state    <= ST_HELD;
                r_cnt      <= '0;
                r_keyValid <= 1'b1;
                r_keyCode  <= w_mappedKey;
                r_digits   <= w_digitsNext;
              end else begin
                r_cnt <= w_cntInc;
              end
            end else begin
              r_state  <= ST_SCAN;
              r_cnt    <= '0;
              r_col    <= {r_col[2:0], r_col[3]};
              r_colIdx <= r_colIdx + 1'b1;
            end
          end
          ST_HELD: begin
            if (w_anyLow) begin
              r_cnt <= '0;
            end else if (w_cntInc == CNT_DONE) begin
              r_state  <= ST_SCAN;
              r_cnt    <= '0;
              r_col    <= {r_col[2:0], r_col[3]};
              r_colIdx <= r_colIdx + 1'b1;
            end else begin
              r_cnt <= w_cntInc;
            end
          end
          default: begin
            r_state <= ST_SCAN;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign col      = r_col;
  assign keyValid = r_keyValid;
  assign keyCode  = r_keyCode;
  assign digits   = r_digits;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE=3. A keypad
// model pulls row[r] low whenever column c is driven low and key (r,c) is
// down. Expected values are worked out by hand from the keypad layout and
// the digit-entry rules.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic [15:0] digits;

  logic [15:0] keys;
  int          testsRun;
  int          testsFailed;
  int          pulseCount;
  int          pulseBase;

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .keyValid (keyValid),
    .keyCode  (keyCode),
    .digits   (digits)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key connects its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Count every cycle keyValid is high, so a pulse longer than one cycle
  // shows up as an extra count.
  initial pulseCount = 0;
  always @(negedge clk) begin
    if (keyValid) pulseCount <= pulseCount + 1;
  end

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Press key (r,c), hold it, release it, and let the scanner see the release.
  task automatic applyStimulus(input int r, input int c, input int holdCycles,
                               input int releaseCycles);
    keys[r*4 + c] = 1'b1;
    repeat (holdCycles) @(negedge clk);
    keys = 16'h0000;
    repeat (releaseCycles) @(negedge clk);
  endtask

  // Move to the first negedge after the column switches to the target.
  task automatic waitColumn(input logic [3:0] target);
    int n;
    n = 0;
    while (col == target && n < 64) begin
      @(negedge clk);
      n++;
    end
    while (col != target && n < 128) begin
      @(negedge clk);
      n++;
    end
    if (col != target) checkOutput("waitColumn timeout", {28'd0, col}, {28'd0, target});
  endtask

  initial begin
    logic [3:0] expCol;
    testsRun    = 0;
    testsFailed = 0;
    keys        = 16'h0000;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state.
    checkOutput("reset col", {28'd0, col}, 32'hE);
    checkOutput("reset keyValid", {31'd0, keyValid}, 32'h0);
    checkOutput("reset keyCode", {28'd0, keyCode}, 32'h0);
    checkOutput("reset digits", {16'd0, digits}, 32'h0);
    rst_n = 1'b1;

    // Idle rotation: column moves after every four edges.
    pulseBase = pulseCount;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      expCol = 4'hF;
      expCol[(i / 4) % 4] = 1'b0;
      if (i % 4 == 0 || i % 4 == 3) checkOutput("idle col", {28'd0, col}, {28'd0, expCol});
    end
    checkOutput("idle no pulse", pulseCount - pulseBase, 0);

    // Steady press of '6'.
    pulseBase = pulseCount;
    applyStimulus(1, 2, 100, 40);
    checkOutput("key6 pulses", pulseCount - pulseBase, 1);
    checkOutput("key6 code", {28'd0, keyCode}, 32'h6);
    checkOutput("key6 digits", {16'd0, digits}, 32'h0006);

    // 1..5 in sequence; the 6 drops off the top.
    pulseBase = pulseCount;
    applyStimulus(0, 0, 60, 40);
    applyStimulus(0, 1, 60, 40);
    applyStimulus(0, 2, 60, 40);
    applyStimulus(1, 0, 60, 40);
    applyStimulus(1, 1, 60, 40);
    checkOutput("seq pulses", pulseCount - pulseBase, 5);
    checkOutput("seq code", {28'd0, keyCode}, 32'h5);
    checkOutput("seq digits", {16'd0, digits}, 32'h2345);

    // '*' clears.
    pulseBase = pulseCount;
    applyStimulus(3, 0, 60, 40);
    checkOutput("clear pulses", pulseCount - pulseBase, 1);
    checkOutput("clear code", {28'd0, keyCode}, 32'hE);
    checkOutput("clear digits", {16'd0, digits}, 32'h0);

    // Enter 12, then 'A' leaves the digits alone.
    applyStimulus(0, 0, 60, 40);
    applyStimulus(0, 1, 60, 40);
    checkOutput("pre-A digits", {16'd0, digits}, 32'h0012);
    pulseBase = pulseCount;
    applyStimulus(0, 3, 60, 40);
    checkOutput("keyA pulses", pulseCount - pulseBase, 1);
    checkOutput("keyA code", {28'd0, keyCode}, 32'hA);
    checkOutput("keyA digits", {16'd0, digits}, 32'h0012);

    // Glitch on (1,1) lasting two samples only.
    pulseBase = pulseCount;
    waitColumn(4'b1101);
    keys[1*4 + 1] = 1'b1;
    repeat (8) @(negedge clk);
    keys = 16'h0000;
    repeat (60) @(negedge clk);
    checkOutput("glitch no pulse", pulseCount - pulseBase, 0);

    // Bounce on (1,1): two samples down, one up, then stable.
    pulseBase = pulseCount;
    waitColumn(4'b1101);
    keys[1*4 + 1] = 1'b1;
    repeat (8) @(negedge clk);
    keys = 16'h0000;
    repeat (4) @(negedge clk);
    checkOutput("bounce no pulse", pulseCount - pulseBase, 0);
    applyStimulus(1, 1, 100, 40);
    checkOutput("bounce pulses", pulseCount - pulseBase, 1);
    checkOutput("bounce code", {28'd0, keyCode}, 32'h5);
    checkOutput("bounce digits", {16'd0, digits}, 32'h0125);

    // Two keys in column 0: lowest row ('1') wins.
    pulseBase = pulseCount;
    keys[0*4 + 0] = 1'b1;
    keys[2*4 + 0] = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("dual pulses", pulseCount - pulseBase, 1);
    checkOutput("dual code", {28'd0, keyCode}, 32'h1);
    checkOutput("dual digits", {16'd0, digits}, 32'h1251);

    // Reset while HELD, keys still down.
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("held-reset col", {28'd0, col}, 32'hE);
    checkOutput("held-reset keyValid", {31'd0, keyValid}, 32'h0);
    checkOutput("held-reset keyCode", {28'd0, keyCode}, 32'h0);
    checkOutput("held-reset digits", {16'd0, digits}, 32'h0);
    pulseBase = pulseCount;
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("redetect pulses", pulseCount - pulseBase, 1);
    checkOutput("redetect code", {28'd0, keyCode}, 32'h1);
    checkOutput("redetect digits", {16'd0, digits}, 32'h0001);
    keys = 16'h0000;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
